// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between the decoder and the HI/LO mul/div unit.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            rdhilo;
  logic            flush;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;
  logic            done;
  logic            stall;

  modport master (
    output start, op, a, b, rdhilo, flush,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, a, b, rdhilo, flush,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO registers.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an issue; MTHI/MTLO write HI/LO directly
// RUN   | one multiplier bit (shift-add) or quotient bit (restoring) per edge
// FIXUP | sign correction, HI/LO write, done pulse on the following cycle
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     opnd_q;
  logic [XLEN-1:0]     a_orig_q;
  logic [XLEN-1:0]     hi_q, lo_q;
  logic                is_div_q, sgn_q, sign_a_q, sign_b_q, b_zero_q, done_q;

  logic                accept, mt_write;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       mul_sum, div_trial;
  logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;
  logic [XLEN-1:0]     res_hi, res_lo;

  // Only MULx/DIVx (op[2]==0) launch an iteration; 11x is ignored entirely.
  assign accept   = (state_q == S_IDLE) && bus.start && !bus.op[2];
  assign mt_write = (state_q == S_IDLE) && bus.start && (bus.op[2:1] == 2'b10);
  assign mag_a    = (bus.op[0] && bus.a[XLEN-1]) ? -bus.a : bus.a;
  assign mag_b    = (bus.op[0] && bus.b[XLEN-1]) ? -bus.b : bus.b;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: flush abandons RUN or FIXUP without writing results.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (bus.flush) state_d = S_IDLE;
               else if (cnt_q == '0) state_d = S_FIXUP;
      S_FIXUP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: stall only holds the pipeline while an operation is already running.
  always_comb begin
    bus.busy  = (state_q != S_IDLE);
    bus.stall = bus.busy && (bus.rdhilo || bus.start);
    bus.done  = done_q;
    bus.hi    = hi_q;
    bus.lo    = lo_q;
  end

  // Single iteration of each algorithm. The multiply keeps {partial, multiplier};
  // the divide keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Sign correction; divide by zero reports all-ones quotient and the raw dividend.
  always_comb begin
    prod_fix = (sgn_q && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
    res_hi   = prod_fix[2*XLEN-1:XLEN];
    res_lo   = prod_fix[XLEN-1:0];
    if (is_div_q) begin
      if (b_zero_q) begin
        res_lo = '1;
        res_hi = a_orig_q;
      end else begin
        res_lo = (sgn_q && (sign_a_q ^ sign_b_q)) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        res_hi = (sgn_q && sign_a_q) ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      end
    end
  end

  // Datapath: operand latch, iteration, HI/LO writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_orig_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      sgn_q    <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == S_FIXUP) && !bus.flush;
      if (accept) begin
        is_div_q <= bus.op[1];
        sgn_q    <= bus.op[0];
        sign_a_q <= bus.op[0] & bus.a[XLEN-1];
        sign_b_q <= bus.op[0] & bus.b[XLEN-1];
        b_zero_q <= (bus.b == '0);
        a_orig_q <= bus.a;
        opnd_q   <= bus.op[1] ? mag_b : mag_a;
        acc_q    <= {{XLEN{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
        cnt_q    <= CW'(XLEN-1);
      end else if ((state_q == S_RUN) && !bus.flush) begin
        acc_q <= is_div_q ? div_next : mul_next;
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
      if ((state_q == S_FIXUP) && !bus.flush) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (mt_write) begin
        if (bus.op[0]) lo_q <= bus.a;
        else           hi_q <= bus.a;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one mul/div at the current cycle and check the exact XLEN+2 latency.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    chk({tag, "_busy_e1"}, 64'(bus.busy), 64'd1);
    repeat (XLEN) @(posedge clk);
    #1;
    chk({tag, "_busy_e33"}, 64'(bus.busy), 64'd1);
    chk({tag, "_done_e33"}, 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_e34"}, 64'(bus.done), 64'd1);
    chk({tag, "_busy_e34"}, 64'(bus.busy), 64'd0);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    bus.rdhilo = 1'b0; bus.flush = 1'b0;
    #1;
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    #11 reset = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg", 3'b001, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    bus.flush = 1'b1;  // flush in IDLE must not block the issue
    run_op("divu", 3'b010, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_neg", 3'b011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_by0", 3'b011, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
    run_op("divu_by0", 3'b010, 32'h87654321, 32'd0, 32'h87654321, 32'hFFFFFFFF);
    run_op("div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MTHI in IDLE
    bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'hCAFEBABE; bus.rdhilo = 1'b1;
    #1 chk("mthi_stall", 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("mthi_hi", 64'(bus.hi), 64'hCAFEBABE);
    chk("mthi_lo_keep", 64'(bus.lo), 64'h80000000);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    chk("mthi_done", 64'(bus.done), 64'd0);

    // Reserved op
    bus.start = 1'b1; bus.op = 3'b110; bus.a = 32'h1234;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("rsvd_busy", 64'(bus.busy), 64'd0);
    chk("rsvd_hi", 64'(bus.hi), 64'hCAFEBABE);
    chk("rsvd_lo", 64'(bus.lo), 64'h80000000);

    // MULTU 2*3 with rdhilo and a held MTLO start throughout
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd2; bus.b = 32'd3;
    #1 chk("issue_nostall", 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    bus.op = 3'b101; bus.a = 32'h55;
    for (int i = 0; i < 33; i++) begin
      chk($sformatf("run_stall_%0d", i), 64'(bus.stall), 64'd1);
      @(posedge clk); #1;
    end
    chk("m23_done", 64'(bus.done), 64'd1);
    chk("m23_stall", 64'(bus.stall), 64'd0);
    chk("m23_lo", 64'(bus.lo), 64'd6);
    chk("m23_hi", 64'(bus.hi), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.rdhilo = 1'b0;
    chk("mtlo_after_fixup", 64'(bus.lo), 64'h55);
    chk("mtlo_hi_keep", 64'(bus.hi), 64'd0);
    chk("mtlo_done", 64'(bus.done), 64'd0);

    // Flush at cycle 10 of a MULTU
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd5; bus.b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_done", 64'(bus.done), 64'd0);
    chk("flush_hi", 64'(bus.hi), 64'd0);
    chk("flush_lo", 64'(bus.lo), 64'h55);
    repeat (30) @(posedge clk);
    #1;
    chk("flush_lo_late", 64'(bus.lo), 64'h55);
    chk("flush_busy_late", 64'(bus.busy), 64'd0);

    // Async reset at cycle 20 of a DIV
    bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h1111;
    @(posedge clk); #1;
    bus.op = 3'b011; bus.a = 32'd1000; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("pre_rst_hi", 64'(bus.hi), 64'h1111);
    repeat (19) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("arst_hi", 64'(bus.hi), 64'd0);
    chk("arst_lo", 64'(bus.lo), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    #2 reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("post_rst_busy", 64'(bus.busy), 64'd0);
    chk("post_rst_hi", 64'(bus.hi), 64'd0);
    chk("post_rst_lo", 64'(bus.lo), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multiply/divide unit that owns the HI/LO registers for the single-cycle MIPS core. It replaces the combinational multiply path inside the ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decoder and runs multiply/divide over XLEN+2 cycles. It raises a stall toward the PC/regfile while a dependent HI/LO read or a new mul/div issue arrives during an operation.

Parameters:
XLEN, 32, operand width; also the iteration count (one result bit per cycle).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  issue request, valid with op/a/b
op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x reserved (no-op)
a  input  XLEN  rs operand (multiplicand / dividend / MTxx source)
b  input  XLEN  rt operand (multiplier / divisor)
rdhilo  input  1  decoder is executing MFHI/MFLO this cycle
flush  input  1  cancel in-flight mul/div
hi  output  XLEN  HI register
lo  output  XLEN  LO register
busy  output  1  mul/div in progress
done  output  1  one-cycle pulse: hi/lo just updated by mul/div
stall  output  1  hold PC and suppress regwrite this cycle

Behaviour:
- Reset (reset=0, async): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Takes effect immediately, including mid-operation. The partial result is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter XLEN-1 down to 0.
  - FIXUP: busy=1.
- IDLE, start with op MULx/DIVx: latch the operands at the edge, go to RUN, busy=1 from the next cycle.
  - Signed ops latch magnitudes plus the sign of a and the sign of b.
- IDLE, start with MTHI/MTLO: hi<=a or lo<=a at that edge. No busy, no done, state stays IDLE.
- RUN, multiply: shift-add over a 2*XLEN accumulator, one multiplier bit per edge.
- RUN, divide: restoring division, one quotient bit per edge.
- RUN exit: after the step at counter==0, go to FIXUP.
- FIXUP (one edge) writes hi/lo, asserts done for the following cycle, and returns to IDLE with busy=0.
  - Signed multiply: negate the 2*XLEN product if the operand signs differ.
  - Signed divide: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
- Latency: the accepting edge is edge 1; hi/lo update at edge XLEN+2 (34 for XLEN=32). busy is high between edge 1 and edge XLEN+2.
- Divide by zero (signed or unsigned): lo=all ones, hi=original a. Latency is unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (the natural magnitude result; no special case).
- stall = busy & (rdhilo | start), combinational.
  - A start in IDLE never stalls; the issuing instruction retires immediately.
- start while busy: ignored. The decoder holds it because stall=1, and it is accepted in the first IDLE cycle.
- start coincident with the FIXUP edge: not accepted; accepted in the next cycle.
- flush while busy: return to IDLE at the next edge. hi/lo unchanged, no done.
  - flush has priority over a FIXUP write on the same edge.
  - flush in IDLE: no effect; a simultaneous start is still accepted.
- hi/lo hold their values at all times except MTxx, FIXUP, and reset.
- Reserved ops: no state change.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> at edge 34, hi=0xFFFFFFFE, lo=0x00000001, done=1 for one cycle, busy=0 after.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU a=100 b=7 -> lo=14, hi=2. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0xCAFEBABE in IDLE -> hi=0xCAFEBABE next cycle, busy/done stay 0. Then MULTU 2*3 with rdhilo=1 during RUN -> stall=1 every busy cycle, stall=0 in the done cycle, lo=6, hi=0.
- MULTU started, flush at cycle 10 -> busy=0 next cycle, hi/lo keep their prior values, no done. Separately, reset pulled low at cycle 20 of a DIV -> hi=lo=0 and busy=0 immediately, without waiting for a clock edge.
